// File: rtl/vec_player_pkg.sv
// Shared types and constants for the vector player / capture block.
// The optional signature register is enabled with the VEC_PLAYER_MISR_EN macro.
package vec_player_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_APPLY   = 3'd1,
    ST_WAIT    = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  localparam logic [15:0] MISR_POLY = 16'h100B;
  localparam logic [15:0] MISR_SEED = 16'hFFFF;

  // One MISR step: shift left, fold the feedback polynomial, absorb the data word.
  function automatic logic [15:0] misr_next(input logic [15:0] sig_cur,
                                            input logic [15:0] data);
    return {sig_cur[14:0], 1'b0} ^ (sig_cur[15] ? MISR_POLY : 16'h0000) ^ data;
  endfunction

endpackage

// File: rtl/vec_player_mem.sv
// Vector + expected-response storage: synchronous write, asynchronous read.
// Contents have no reset and survive the block reset.
module vec_player_mem #(
  parameter int VEC_W = 36,
  parameter int RSP_W = 7,
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [VEC_W-1:0] wvec,
  input  logic [RSP_W-1:0] wexp,
  input  logic [AW-1:0]    raddr,
  output logic [VEC_W-1:0] rvec,
  output logic [RSP_W-1:0] rexp
);
  import vec_player_pkg::*;

  logic [VEC_W-1:0] vec_mem [DEPTH];
  logic [RSP_W-1:0] exp_mem [DEPTH];

  // Both arrays share one write port so a vector and its response land together.
  always_ff @(posedge clk) begin
    if (we) begin
      vec_mem[waddr] <= wvec;
      exp_mem[waddr] <= wexp;
    end
  end

  assign rvec = vec_mem[raddr];
  assign rexp = exp_mem[raddr];

endmodule

// File: rtl/vec_player_capture.sv
// Plays stored stimulus vectors into a combinational core, captures each
// response SETTLE cycles after it is applied, streams it out and counts
// mismatches. Define VEC_PLAYER_MISR_EN to add the 16-bit response signature.
//
// Handshake: there is no back-pressure. cfg_we and start are single-cycle
// requests accepted only while busy is low; cap_valid and done are one-cycle
// strobes that the consumer must take in the cycle they are high.
module vec_player_capture #(
  parameter int VEC_W  = 36,
  parameter int RSP_W  = 7,
  parameter int DEPTH  = 32,
  parameter int SETTLE = 1,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [AW-1:0]    cfg_addr,
  input  logic [VEC_W-1:0] cfg_vec,
  input  logic [RSP_W-1:0] cfg_exp,
  input  logic             start,
  input  logic [AW:0]      num_vec,
  output logic [VEC_W-1:0] dut_in,
  input  logic [RSP_W-1:0] dut_out,
  output logic             busy,
  output logic             done,
  output logic             cap_valid,
  output logic [RSP_W-1:0] cap_data,
  output logic [AW-1:0]    cap_idx,
  output logic [AW:0]      mismatch_cnt,
  output logic             fail_valid,
  output logic [AW-1:0]    first_fail_idx
`ifdef VEC_PLAYER_MISR_EN
  ,
  output logic [15:0]      sig
`endif
);
  import vec_player_pkg::*;

  localparam int WCW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [AW:0] DEPTH_V = (AW+1)'(DEPTH);

  state_t           state_q, state_d;
  logic [AW-1:0]    idx_q;
  logic [AW-1:0]    last_q;
  logic [WCW-1:0]   wait_q;
  logic [AW:0]      num_clamped;
  logic [VEC_W-1:0] rd_vec;
  logic [RSP_W-1:0] rd_exp;
  logic             mem_we;

  assign mem_we      = cfg_we && (state_q == ST_IDLE);
  assign num_clamped = (num_vec > DEPTH_V) ? DEPTH_V : num_vec;
  assign busy        = (state_q != ST_IDLE);
  assign done        = (state_q == ST_DONE);

  vec_player_mem #(
    .VEC_W (VEC_W),
    .RSP_W (RSP_W),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (cfg_addr),
    .wvec  (cfg_vec),
    .wexp  (cfg_exp),
    .raddr (idx_q),
    .rvec  (rd_vec),
    .rexp  (rd_exp)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state: one period is APPLY, SETTLE-1 WAIT cycles, then CAPTURE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (start) state_d = (num_vec == '0) ? ST_DONE : ST_APPLY;
      ST_APPLY:   state_d = (SETTLE == 1) ? ST_CAPTURE : ST_WAIT;
      ST_WAIT:    if (wait_q == WCW'(1)) state_d = ST_CAPTURE;
      ST_CAPTURE: state_d = (idx_q == last_q) ? ST_DONE : ST_APPLY;
      ST_DONE:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Datapath: run setup, vector apply, settle countdown, capture and scoring.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q          <= '0;
      last_q         <= '0;
      wait_q         <= '0;
      dut_in         <= '0;
      cap_valid      <= 1'b0;
      cap_data       <= '0;
      cap_idx        <= '0;
      mismatch_cnt   <= '0;
      fail_valid     <= 1'b0;
      first_fail_idx <= '0;
    end else begin
      cap_valid <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            idx_q          <= '0;
            last_q         <= AW'(num_clamped - 1'b1);
            mismatch_cnt   <= '0;
            fail_valid     <= 1'b0;
            first_fail_idx <= '0;
          end
        end
        ST_APPLY: begin
          dut_in <= rd_vec;
          wait_q <= WCW'(SETTLE - 1);
        end
        ST_WAIT: begin
          wait_q <= wait_q - 1'b1;
        end
        ST_CAPTURE: begin
          cap_valid <= 1'b1;
          cap_data  <= dut_out;
          cap_idx   <= idx_q;
          if (dut_out != rd_exp) begin
            mismatch_cnt <= mismatch_cnt + 1'b1;
            if (!fail_valid) begin
              fail_valid     <= 1'b1;
              first_fail_idx <= idx_q;
            end
          end
          if (idx_q != last_q) idx_q <= idx_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef VEC_PLAYER_MISR_EN
  // Response signature: seeded at run start, folded on every capture edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sig <= '0;
    end else if (state_q == ST_IDLE && start) begin
      sig <= MISR_SEED;
    end else if (state_q == ST_CAPTURE) begin
      sig <= misr_next(sig, 16'(dut_out));
    end
  end
`endif

endmodule

// File: tb/tb_vec_player_capture.sv
// Bench for vec_player_capture: two instances (SETTLE=1 and SETTLE=3) share
// the stimulus; a schedule-based model predicts every output every cycle.
module tb_vec_player_capture;
  localparam int VEC_W = 36;
  localparam int RSP_W = 7;
  localparam int DEPTH = 32;
  localparam int AW    = 5;
  localparam int NI    = 2;

  // ---------------- clock / reset / stimulus signals ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst, cfg_we, start, zero_rsp;
  logic [AW-1:0]    cfg_addr;
  logic [VEC_W-1:0] cfg_vec;
  logic [RSP_W-1:0] cfg_exp;
  logic [AW:0]      num_vec;

  logic [VEC_W-1:0] dut_in_w   [NI];
  logic [RSP_W-1:0] dut_out_w  [NI];
  logic             busy_w     [NI];
  logic             done_w     [NI];
  logic             cap_valid_w[NI];
  logic [RSP_W-1:0] cap_data_w [NI];
  logic [AW-1:0]    cap_idx_w  [NI];
  logic [AW:0]      mm_w       [NI];
  logic             fv_w       [NI];
  logic [AW-1:0]    ff_w       [NI];
`ifdef VEC_PLAYER_MISR_EN
  logic [15:0]      sig_w      [NI];
`endif

  int total = 0;
  int bad   = 0;

  // Combinational core standing in for the ISCAS circuit.
  function automatic logic [RSP_W-1:0] core_f(input logic [VEC_W-1:0] v);
    return v[6:0] ^ v[13:7] ^ v[20:14] ^ v[27:21] ^ v[34:28] ^ {6'b0, v[35]} ^ (v[6:0] & v[13:7]);
  endfunction

  function automatic int settle_of(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_dut
    assign dut_out_w[g] = zero_rsp ? '0 : core_f(dut_in_w[g]);
    vec_player_capture #(
      .VEC_W (VEC_W), .RSP_W (RSP_W), .DEPTH (DEPTH), .SETTLE ((g == 0) ? 1 : 3)
    ) u_dut (
      .clk            (clk),
      .rst            (rst),
      .cfg_we         (cfg_we),
      .cfg_addr       (cfg_addr),
      .cfg_vec        (cfg_vec),
      .cfg_exp        (cfg_exp),
      .start          (start),
      .num_vec        (num_vec),
      .dut_in         (dut_in_w[g]),
      .dut_out        (dut_out_w[g]),
      .busy           (busy_w[g]),
      .done           (done_w[g]),
      .cap_valid      (cap_valid_w[g]),
      .cap_data       (cap_data_w[g]),
      .cap_idx        (cap_idx_w[g]),
      .mismatch_cnt   (mm_w[g]),
      .fail_valid     (fv_w[g]),
      .first_fail_idx (ff_w[g])
`ifdef VEC_PLAYER_MISR_EN
      ,
      .sig            (sig_w[g])
`endif
    );
  end

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [VEC_W-1:0] dut_in;
    logic             busy;
    logic             done;
    logic             cap_valid;
    logic [RSP_W-1:0] cap_data;
    logic [AW-1:0]    cap_idx;
    logic [AW:0]      mm;
    logic             fv;
    logic [AW-1:0]    ff;
    logic [15:0]      sig;
  } obs_t;

  obs_t             held [NI];
  bit               active [NI];
  int               rs [NI];
  int               rn [NI];
  bit               rzero [NI];
  logic [VEC_W-1:0] mvec [NI][DEPTH];
  logic [RSP_W-1:0] mexp [NI][DEPTH];
  logic [VEC_W-1:0] rvec [NI][DEPTH];
  logic [RSP_W-1:0] rexp [NI][DEPTH];
  int               ecount = 0;
  bit               live = 0;
  obs_t             mdl_cur;
  obs_t             cmp_e;

  function automatic logic [15:0] misr_model(input logic [15:0] s, input logic [RSP_W-1:0] r);
    logic [15:0] fb;
    fb = (s >= 16'h8000) ? 16'h100B : 16'h0000;
    return 16'((32'(s) * 2) % 65536) ^ fb ^ 16'(r);
  endfunction

  // Outputs after edge t: a run started at edge s applies vector k at edge
  // s+1+k*P and its capture is visible after edge s+(k+1)*P, P = SETTLE+1.
  function automatic obs_t compute_exp(input int i, input int t);
    obs_t e;
    int d, p, c, a;
    logic [RSP_W-1:0] r;
    e = held[i];
    e.busy = 1'b0; e.done = 1'b0; e.cap_valid = 1'b0;
    if (!active[i]) return e;
    p = settle_of(i) + 1;
    d = t - rs[i];
    e.busy      = (d <= rn[i] * p);
    e.done      = (d == rn[i] * p);
    e.cap_valid = (d > 0) && (d % p == 0) && (d / p <= rn[i]);
    c = d / p;             if (c > rn[i]) c = rn[i];
    a = (d >= 1) ? (d - 1) / p + 1 : 0; if (a > rn[i]) a = rn[i];
    if (a > 0) e.dut_in = rvec[i][a-1];
    e.mm = '0; e.fv = 1'b0; e.ff = '0; e.sig = 16'hFFFF;
    for (int k = 0; k < c; k++) begin
      r = rzero[i] ? '0 : core_f(rvec[i][k]);
      e.cap_data = r;
      e.cap_idx  = AW'(k);
      if (r != rexp[i][k]) begin
        e.mm = e.mm + 1'b1;
        if (!e.fv) begin e.fv = 1'b1; e.ff = AW'(k); end
      end
      e.sig = misr_model(e.sig, r);
    end
    return e;
  endfunction

  // Model edge step: honour writes/start only for instances that are idle.
  always @(posedge clk) begin
    ecount = ecount + 1;
    live = 1;
    for (int i = 0; i < NI; i++) begin
      if (rst) begin
        active[i] = 0;
        held[i]   = '0;
      end else begin
        mdl_cur = compute_exp(i, ecount - 1);
        if (!mdl_cur.busy) begin
          if (cfg_we) begin
            mvec[i][cfg_addr] = cfg_vec;
            mexp[i][cfg_addr] = cfg_exp;
          end
          if (start) begin
            held[i]   = mdl_cur;
            active[i] = 1;
            rs[i]     = ecount;
            rn[i]     = (int'(num_vec) > DEPTH) ? DEPTH : int'(num_vec);
            rzero[i]  = zero_rsp;
            for (int k = 0; k < DEPTH; k++) begin
              rvec[i][k] = mvec[i][k];
              rexp[i][k] = mexp[i][k];
            end
          end
        end
      end
    end
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input int i, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s inst=%0d edge=%0d got=%0h want=%0h", name, i, ecount, act, req);
    end
  endtask

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (live) begin
      for (int i = 0; i < NI; i++) begin
        cmp_e = compute_exp(i, ecount);
        chk("dut_in",         i, 64'(dut_in_w[i]),    64'(cmp_e.dut_in));
        chk("busy",           i, 64'(busy_w[i]),      64'(cmp_e.busy));
        chk("done",           i, 64'(done_w[i]),      64'(cmp_e.done));
        chk("cap_valid",      i, 64'(cap_valid_w[i]), 64'(cmp_e.cap_valid));
        chk("cap_data",       i, 64'(cap_data_w[i]),  64'(cmp_e.cap_data));
        chk("cap_idx",        i, 64'(cap_idx_w[i]),   64'(cmp_e.cap_idx));
        chk("mismatch_cnt",   i, 64'(mm_w[i]),        64'(cmp_e.mm));
        chk("fail_valid",     i, 64'(fv_w[i]),        64'(cmp_e.fv));
        chk("first_fail_idx", i, 64'(ff_w[i]),        64'(cmp_e.ff));
`ifdef VEC_PLAYER_MISR_EN
        chk("sig",            i, 64'(sig_w[i]),       64'(cmp_e.sig));
`endif
      end
    end
  end

  // ---------------- driver tasks ----------------
  int busy1_cnt, cap0_cnt, done0_cnt;

  function automatic logic [VEC_W-1:0] rand_vec();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[VEC_W-1:0];
  endfunction

  task automatic write(input int addr, input logic [VEC_W-1:0] v, input logic [RSP_W-1:0] x);
    cfg_we = 1'b1; cfg_addr = AW'(addr); cfg_vec = v; cfg_exp = x;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    bit fin;
    fin = 0; busy1_cnt = 0; cap0_cnt = 0; done0_cnt = 0;
    for (int c = 0; c < budget; c++) begin
      if (busy_w[1])      busy1_cnt++;
      if (cap_valid_w[0]) cap0_cnt++;
      if (done_w[0])      done0_cnt++;
      if (!busy_w[0] && !busy_w[1]) begin fin = 1; break; end
      @(negedge clk);
    end
    total++;
    if (!fin) begin
      bad++;
      $display("FAIL run_timeout got=busy want=idle within %0d cycles", budget);
    end
  endtask

  task automatic run(input int n);
    num_vec = (AW+1)'(n); start = 1'b1;
    @(negedge clk);
    start = 1'b0; cfg_we = 1'b0;
    wait_idle(600);
  endtask

  // ---------------- main sequence ----------------
  logic [VEC_W-1:0] saved_vec;
  logic [RSP_W-1:0] saved_cap;
  int               rst_at, seen_done;

  initial begin
    rst = 1'b1; cfg_we = 1'b0; start = 1'b0; zero_rsp = 1'b0;
    cfg_addr = '0; cfg_vec = '0; cfg_exp = '0; num_vec = '0;
    repeat (3) @(negedge clk);
    chk("reset_dut_in",    0, 64'(dut_in_w[0]), 64'h0);
    chk("reset_busy",      1, 64'(busy_w[1]),   64'h0);
    chk("reset_mismatch",  0, 64'(mm_w[0]),     64'h0);
    rst = 1'b0;

    for (int a = 0; a < DEPTH; a++) begin
      saved_vec = rand_vec();
      write(a, saved_vec, core_f(saved_vec));
    end

    // Basic 4-vector run with correct expectations.
    for (int k = 0; k < 4; k++) write(k, VEC_W'(k + 1), core_f(VEC_W'(k + 1)));
    run(4);
    chk("basic_caps",      0, 64'(cap0_cnt),      64'd4);
    chk("basic_last_idx",  0, 64'(cap_idx_w[0]),  64'd3);
    chk("basic_last_data", 0, 64'(cap_data_w[0]), 64'h04);
    chk("basic_mismatch",  0, 64'(mm_w[0]),       64'd0);
    chk("basic_fail",      0, 64'(fv_w[0]),       64'd0);
    chk("basic_busy_s3",   1, 64'(busy1_cnt),     64'd17);

    // SETTLE=3 with two vectors: period 4, busy 9 cycles.
    run(2);
    chk("settle3_busy", 1, 64'(busy1_cnt), 64'd9);

    // Corrupt two expectations.
    write(2, VEC_W'(3), core_f(VEC_W'(3)) ^ 7'h01);
    write(3, VEC_W'(4), core_f(VEC_W'(4)) ^ 7'h10);
    run(4);
    for (int i = 0; i < NI; i++) begin
      chk("corrupt_mismatch", i, 64'(mm_w[i]), 64'd2);
      chk("corrupt_fail",     i, 64'(fv_w[i]), 64'd1);
      chk("corrupt_first",    i, 64'(ff_w[i]), 64'd2);
    end
    write(2, VEC_W'(3), core_f(VEC_W'(3)));
    write(3, VEC_W'(4), core_f(VEC_W'(4)));
    run(4);
    chk("restore_mismatch", 1, 64'(mm_w[1]), 64'd0);
    chk("restore_fail",     1, 64'(fv_w[1]), 64'd0);

    // Zero-length run.
    saved_vec = dut_in_w[0];
    run(0);
    chk("zero_done",   0, 64'(done0_cnt),   64'd1);
    chk("zero_caps",   0, 64'(cap0_cnt),    64'd0);
    chk("zero_dut_in", 0, 64'(dut_in_w[0]), 64'(saved_vec));

    // Write and start in the same idle cycle: run must see the new entry.
    cfg_we = 1'b1; cfg_addr = '0; cfg_vec = 36'hA_BCDE_1234; cfg_exp = core_f(36'hA_BCDE_1234);
    run(1);
    chk("same_cycle_write", 0, 64'(dut_in_w[0]), 64'hA_BCDE_1234);

    // start / cfg_we while busy are ignored.
    num_vec = 8; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    cfg_we = 1'b1; cfg_addr = '0; cfg_vec = 36'h5_5555_5555; cfg_exp = '0;
    start = 1'b1; num_vec = 1;
    @(negedge clk);
    cfg_we = 1'b0; start = 1'b0;
    wait_idle(600);
    chk("busy_ignore_idx", 0, 64'(cap_idx_w[0]), 64'd7);
    saved_cap = cap_data_w[1];
    run(1);
    chk("busy_ignore_mem", 0, 64'(dut_in_w[0]), 64'hA_BCDE_1234);

    // Reset during the third vector's WAIT of the SETTLE=3 instance.
    num_vec = 8; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen_done = 0;
    for (int c = 0; c < 9; c++) begin
      if (done_w[0] || done_w[1]) seen_done++;
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_no_done", 0, 64'(seen_done),      64'd0);
    for (int i = 0; i < NI; i++) begin
      chk("midrst_busy",   i, 64'(busy_w[i]),      64'd0);
      chk("midrst_done",   i, 64'(done_w[i]),      64'd0);
      chk("midrst_dut_in", i, 64'(dut_in_w[i]),    64'd0);
      chk("midrst_cap",    i, 64'(cap_data_w[i]),  64'd0);
    end
    run(8);
    chk("midrst_rerun_cap", 1, 64'(cap_data_w[1]), 64'(saved_cap));

    // Randomized runs with ignored pulses and occasional resets.
    for (int it = 0; it < 25; it++) begin
      for (int w = 0; w < int'($urandom_range(0, 3)); w++) begin
        saved_vec = rand_vec();
        write(int'($urandom_range(0, DEPTH - 1)), saved_vec,
              ($urandom_range(0, 3) == 0) ? core_f(saved_vec) ^ RSP_W'($urandom_range(1, 127))
                                           : core_f(saved_vec));
      end
      num_vec = (AW+1)'($urandom_range(0, 2 * DEPTH - 1));
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      rst_at = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 5)) : -1;
      for (int c = 0; c < 6; c++) begin
        if (c == rst_at) begin
          rst = 1'b1; cfg_we = 1'b0; start = 1'b0;
        end else begin
          cfg_we   = ($urandom_range(0, 3) == 0);
          cfg_addr = AW'($urandom_range(0, DEPTH - 1));
          cfg_vec  = rand_vec();
          cfg_exp  = RSP_W'($urandom_range(0, 127));
          start    = ($urandom_range(0, 3) == 0);
          num_vec  = (AW+1)'($urandom_range(0, 2 * DEPTH - 1));
        end
        @(negedge clk);
        rst = 1'b0; cfg_we = 1'b0; start = 1'b0;
      end
      wait_idle(600);
    end

`ifdef VEC_PLAYER_MISR_EN
    zero_rsp = 1'b1;
    run(1);
    for (int i = 0; i < NI; i++) chk("misr_one_zero", i, 64'(sig_w[i]), 64'hEFF5);
    zero_rsp = 1'b0;
`endif

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time bound.
  initial begin
    #2000000;
    bad++;
    $display("FAIL watchdog got=running want=finished");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
